goldschmidt_divisor_param: RTL and testbench

Parametrised, handshaked successor to the fixed 32-bit Goldschmidt divider. Computes the unsigned integer quotient and remainder of dividendo/divisor with an iterative Goldschmidt multiplicative loop. A final one-step correction makes the results exact (floor), not approximate. It sits as a multi-cycle functional unit beside the ALU and is driven by a start/done handshake.

---
 rtl/goldschmidt_pkg.sv | 32 +++
 rtl/goldschmidt_lzc.sv | 31 +++
 rtl/goldschmidt_divisor_param.sv | 162 ++++++++++++++++
 tb/tb_goldschmidt_divisor_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/goldschmidt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goldschmidt_pkg : shared states and sizing helpers for the divider   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package goldschmidt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    CORR = 2'd3
  } gs_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITERS = 5;
  localparam int DEF_GUARD = 4;

  function automatic int frac_bits(input int width, input int guard);
    return width + guard;
  endfunction

  // Iteration counter width, clog2(ITERS), kept at least one bit wide.
  function automatic int cnt_bits(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  localparam int DEF_FRAC  = frac_bits(DEF_WIDTH, DEF_GUARD);
  localparam int DEF_CNT_W = cnt_bits(DEF_ITERS);

endpackage
`default_nettype wire

// File: rtl/goldschmidt_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goldschmidt_lzc : combinational leading-zero counter (zero gives 0)  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module goldschmidt_lzc
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH)-1:0] count
);

  localparam int LZW = $clog2(WIDTH);

  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/goldschmidt_divisor_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goldschmidt_divisor_param : handshaked Goldschmidt divider, exact    |
// | floor quotient/remainder after one correction step. Revision 1.0     |
// +----------------------------------------------------------------------+
module goldschmidt_divisor_param
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 5,
  parameter int GUARD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_zero
);

  localparam int FRAC  = frac_bits(WIDTH, GUARD);
  localparam int NW    = WIDTH + FRAC;
  localparam int FW    = FRAC + 2;
  localparam int CNT_W = cnt_bits(ITERS);
  localparam int LZW   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  gs_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs;
  logic [NW-1:0]    n_acc;
  logic [FRAC-1:0]  d_acc;

  logic [LZW-1:0]     lz;
  logic [WIDTH-1:0]   dvs_norm;
  logic [NW-1:0]      n0;
  logic [FRAC-1:0]    d0;
  logic [FW-1:0]      f;
  logic [NW+FW-1:0]   n_prod;
  logic [FRAC+FW-1:0] d_prod;
  logic [NW-1:0]      n_next;
  logic [FRAC-1:0]    d_next;

  logic [WIDTH-1:0]   q_raw, q_fix, r_fix;
  logic [2*WIDTH-1:0] qb, r_full;
  logic [WIDTH+1:0]   r_s;
  logic               unused_bits;

  goldschmidt_lzc #(.WIDTH(WIDTH)) u_lzc (
    .value (dvs),
    .count (lz)
  );

  // Normalise the divisor into [0.5,1) and scale the dividend by the same shift.
  always_comb begin
    dvs_norm = dvs << lz;
    d0       = FRAC'(dvs_norm) << GUARD;
    n0       = (NW'(dvd) << GUARD) << lz;
  end

  always_comb begin
    f      = (FW'(2) << FRAC) - FW'(d_acc);
    n_prod = {{FW{1'b0}}, n_acc} * {{NW{1'b0}}, f};
    d_prod = {{FW{1'b0}}, d_acc} * {{FRAC{1'b0}}, f};
    n_next = n_prod[FRAC +: NW];
    d_next = d_prod[FRAC +: FRAC];
  end

  // The truncated estimate is within one of the true quotient on either side.
  always_comb begin
    q_raw  = n_acc[FRAC +: WIDTH];
    qb     = {{WIDTH{1'b0}}, q_raw} * {{WIDTH{1'b0}}, dvs};
    r_full = {{WIDTH{1'b0}}, dvd} - qb;
    r_s    = r_full[WIDTH+1:0];
    q_fix  = q_raw;
    r_fix  = r_s[WIDTH-1:0];
    if (r_s[WIDTH+1]) begin
      q_fix = q_raw - WIDTH'(1);
      r_fix = r_s[WIDTH-1:0] + dvs;
    end else if (r_s >= {2'b00, dvs}) begin
      q_fix = q_raw + WIDTH'(1);
      r_fix = r_s[WIDTH-1:0] - dvs;
    end
  end

  assign unused_bits = ^{n_prod[FRAC-1:0], n_prod[NW+FW-1:NW+FRAC],
                         d_prod[FRAC-1:0], d_prod[FRAC+FW-1:2*FRAC],
                         n_acc[FRAC-1:0], r_full[2*WIDTH-1:WIDTH+2]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = NORM;
      NORM:    state_nxt = ITER;
      ITER:    if (cnt == LAST_ITER) state_nxt = CORR;
      CORR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dvd       <= '0;
      dvs       <= '0;
      n_acc     <= '0;
      d_acc     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quociente <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd      <= dividendo;
            dvs      <= divisor;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        NORM: begin
          n_acc <= n0;
          d_acc <= d0;
          cnt   <= '0;
        end
        ITER: begin
          n_acc <= n_next;
          d_acc <= d_next;
          cnt   <= cnt + CNT_W'(1);
        end
        CORR: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (dvs == '0) begin
            quociente <= '1;
            resto     <= dvd;
            div_zero  <= 1'b1;
          end else begin
            quociente <= q_fix;
            resto     <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_divisor_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_goldschmidt_divisor_param : directed and random checks of the     |
// | divider against plain / and %. Revision 1.0                          |
// +----------------------------------------------------------------------+
module tb_goldschmidt_divisor_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividendo, divisor, quociente, resto;
  logic        busy, done, div_zero;

  logic        start8;
  logic [7:0]  dividendo8, divisor8, quociente8, resto8;
  logic        busy8, done8, div_zero8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  goldschmidt_divisor_param #(.WIDTH(32), .ITERS(5), .GUARD(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividendo(dividendo), .divisor(divisor),
    .busy(busy), .done(done), .quociente(quociente), .resto(resto),
    .div_zero(div_zero)
  );

  goldschmidt_divisor_param #(.WIDTH(8), .ITERS(3), .GUARD(4)) dut8 (
    .clock(clock), .reset(reset), .start(start8),
    .dividendo(dividendo8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quociente(quociente8), .resto(resto8),
    .div_zero(div_zero8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge with the DUT idle; returns on the next falling edge.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; dividendo = a; divisor = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait32(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat; bit bok;
    logic [31:0] eq, er;
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    issue32(a, b);
    wait32(lat, bok);
    check({tag, "_lat"}, 64'(lat), 64'd7);
    check({tag, "_q"}, {32'd0, quociente}, {32'd0, eq});
    check({tag, "_r"}, {32'd0, resto}, {32'd0, er});
    check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, b == 0});
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [7:0] eq, er;
    eq = (b == 0) ? 8'hFF : a / b;
    er = (b == 0) ? a : a % b;
    start8 = 1'b1; dividendo8 = a; divisor8 = b;
    @(negedge clock);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_q"}, {56'd0, quociente8}, {56'd0, eq});
    check({tag, "_r"}, {56'd0, resto8}, {56'd0, er});
    check({tag, "_dz"}, {63'd0, div_zero8}, {63'd0, b == 0});
  endtask

  initial begin
    int lat, dones;
    bit bok;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
    start8 = 1'b0; dividendo8 = '0; divisor8 = '0;
    repeat (2) @(negedge clock);
    check("rst_out", {quociente, resto}, 64'd0);
    check("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    issue32(32'h8000_0000, 32'h2000_0000);
    wait32(lat, bok);
    check("pow2_lat", 64'(lat), 64'd7);
    check("pow2_busy_mid", {63'd0, bok}, 64'd1);
    check("pow2_busy_done", {63'd0, busy}, 64'd0);
    check("pow2_q", {32'd0, quociente}, 64'd4);
    check("pow2_r", {32'd0, resto}, 64'd0);
    check("pow2_dz", {63'd0, div_zero}, 64'd0);
    @(negedge clock);
    check("done_pulse", {63'd0, done}, 64'd0);

    op32("max7", 32'hFFFF_FFFF, 32'd7);
    op32("b2b", 32'h1234_5678, 32'd1);
    op32("divz", 32'h0000_ABCD, 32'd0);
    op32("small", 32'd5, 32'd9);

    // A second request while busy must not disturb the first operation.
    issue32(32'd100, 32'd7);
    start = 1'b1; dividendo = 32'hDEAD_BEEF; divisor = 32'd1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    wait32(lat, bok);
    check("ign_lat", 64'(lat + 2), 64'd7);
    check("ign_q", {32'd0, quociente}, 64'd14);
    check("ign_r", {32'd0, resto}, 64'd2);
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("ign_extra_done", 64'(dones), 64'd0);

    issue32(32'hFFFF_0000, 32'd3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_out", {quociente, resto}, 64'd0);
    check("rst_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("rst_mid_nodone", 64'(dones), 64'd0);
    op32("after_rst", 32'd100, 32'd10);

    op8("w8_200_3", 8'd200, 8'd3);
    op8("w8_divz", 8'd77, 8'd0);
    for (int i = 0; i < 300; i++)
      op8("w8_rand", 8'($urandom), 8'($urandom_range(0, 255)));

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'd1 << $urandom_range(0, 31);
        3: begin a = $urandom_range(0, 1000); b = $urandom_range(1001, 32'hFFFF_FFFF); end
        default: b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 32'hFFFF);
      endcase
      op32("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
